// File: rtl/ika9958_host_seq.sv
// ika9958_host_seq: expands host requests into strobed VDP port cycles
module ika9958_host_seq #(
   parameter int STROBE_LEN = 4,
   parameter int GAP_LEN = 2
) (
   input  logic        i_XTAL1,
   input  logic        i_RST,
   input  logic        i_CEN,
   input  logic        i_REQ_VALID,
   output logic        o_REQ_READY,
   input  logic [2:0]  i_REQ_CMD,
   input  logic [16:0] i_REQ_ADDR,
   input  logic [15:0] i_REQ_DATA,
   output logic        o_CSW_n,
   output logic        o_CSR_n,
   output logic [1:0]  o_MODE,
   output logic [7:0]  o_CD_OUT,
   output logic        o_CD_OE,
   input  logic [7:0]  i_CD_IN,
   output logic [7:0]  o_RD_DATA,
   output logic        o_RD_VALID,
   output logic        o_BUSY,
   output logic        o_ERR
);
   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP, ERR} state_t;
   state_t st, nxt;
   logic [2:0] cmd, step, last_step;
   logic [16:0] addr;
   logic [15:0] data;
   logic [3:0] phase;
   logic [7:0] bval, smp;
   logic [1:0] port;
   logic rd, fresh, acc, last, act;
   assign acc = i_REQ_VALID && o_REQ_READY;
   assign last = step == last_step;
   assign act = st == SETUP || st == STROBE || st == HOLD;
   always_comb begin
      port = 2'd1;
      bval = 8'h00;
      rd = 1'b0;
      last_step = 3'd0;
      case (cmd)
         3'd0: begin
            last_step = 3'd1;
            bval = step == 3'd0 ? data[7:0] : {2'b10, addr[5:0]};
         end
         3'd1, 3'd2: begin
            last_step = 3'd3;
            bval = step == 3'd0 ? {5'b0, addr[16:14]} : step == 3'd1 ? 8'h8E :
                   step == 3'd2 ? addr[7:0] : {1'b0, cmd == 3'd1, addr[13:8]};
         end
         3'd3: begin
            port = 2'd0;
            bval = data[7:0];
         end
         3'd4: begin
            port = 2'd0;
            rd = 1'b1;
         end
         3'd5: begin
            last_step = 3'd4;
            rd = step == 3'd2;
            bval = step == 3'd0 ? {4'b0, addr[3:0]} : step == 3'd3 ? 8'h00 : 8'h8F;
         end
         3'd6: begin
            last_step = 3'd3;
            port = step >= 3'd2 ? 2'd2 : 2'd1;
            bval = step == 3'd0 ? {4'b0, addr[3:0]} : step == 3'd1 ? 8'h90 :
                   step == 3'd2 ? data[7:0] : data[15:8];
         end
         default: ;
      endcase
   end
   always_comb begin
      nxt = st;
      case (st)
         IDLE:   if (acc) nxt = i_REQ_CMD == 3'd7 ? ERR : SETUP;
         ERR:    nxt = IDLE;
         SETUP:  if (i_CEN) nxt = STROBE;
         STROBE: if (i_CEN && phase == 4'(STROBE_LEN - 1)) nxt = HOLD;
         HOLD:   if (i_CEN) nxt = GAP_LEN != 0 ? GAP : last ? IDLE : SETUP;
         GAP:    if (i_CEN && phase == 4'(GAP_LEN - 1)) nxt = last ? IDLE : SETUP;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge i_XTAL1) begin
      if (i_RST) begin
         st <= IDLE;
         fresh <= 1'b0;
         cmd <= 3'd0;
         addr <= 17'd0;
         data <= 16'd0;
         step <= 3'd0;
         phase <= 4'd0;
         smp <= 8'd0;
         o_RD_DATA <= 8'd0;
         o_RD_VALID <= 1'b0;
      end else begin
         st <= nxt;
         fresh <= st != IDLE && nxt == IDLE;
         o_RD_VALID <= st == HOLD && i_CEN && rd;
         if (acc) begin
            cmd <= i_REQ_CMD;
            addr <= i_REQ_ADDR;
            data <= i_REQ_DATA;
            step <= 3'd0;
         end else if (nxt == SETUP && st != SETUP && !last) step <= step + 3'd1;
         phase <= st != nxt ? 4'd0 : (i_CEN && phase != 4'hF) ? phase + 4'd1 : phase;
         if (st == STROBE && nxt == HOLD && rd) smp <= i_CD_IN;
         if (st == HOLD && i_CEN && rd) o_RD_DATA <= smp;
      end
   end
   assign o_REQ_READY = st == IDLE && !fresh && !i_RST;
   assign o_MODE = act ? port : 2'd0;
   assign o_CD_OUT = act && !rd ? bval : 8'd0;
   assign o_CD_OE = act && !rd;
   assign o_CSW_n = !(st == STROBE && !rd);
   assign o_CSR_n = !(st == STROBE && rd);
   assign o_BUSY = st != IDLE;
   assign o_ERR = st == ERR;
endmodule

// File: doc/ika9958_host_seq.md
IKA9958_HOST_SEQ -- requirements
Module: ika9958_host_seq

Interface
Parameters:
REQ-001 SHALL have parameter STROBE_LEN, default 4: strobe-low duration in enabled clocks (legal range 1..15).
REQ-002 SHALL have parameter GAP_LEN, default 2: idle enabled clocks after each bus cycle (legal range 0..15).
Ports:
REQ-003 SHALL have i_XTAL1  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have i_RST  in  1  synchronous active-high reset.
REQ-005 SHALL have i_CEN  in  1  clock enable; bus timing advances only when high.
REQ-006 SHALL have i_REQ_VALID  in  1 and o_REQ_READY  out  1  request handshake.
REQ-007 SHALL have i_REQ_CMD  in  3  command; i_REQ_ADDR  in  17  VRAM address / register no. in [5:0] / status or palette index in [3:0]; i_REQ_DATA  in  16  write data.
REQ-008 SHALL have o_CSW_n, o_CSR_n  out  1  VDP write/read strobes; o_MODE  out  2  port select.
REQ-009 SHALL have o_CD_OUT  out  8, o_CD_OE  out  1, i_CD_IN  in  8  data bus.
REQ-010 SHALL have o_RD_DATA  out  8, o_RD_VALID  out  1, o_BUSY  out  1, o_ERR  out  1.

Function
REQ-011 SHALL accept a request on a rising edge where i_REQ_VALID and o_REQ_READY are both high; o_REQ_READY SHALL be high only in IDLE with i_RST low; command and operands are latched on acceptance.
REQ-012 SHALL expand each command into port cycles (port:byte), in order:
- 0 REGWR: P1:DATA[7:0], P1:0x80|ADDR[5:0].
- 1 VWSETUP: P1:{5'b0,ADDR[16:14]}, P1:0x8E, P1:ADDR[7:0], P1:0x40|ADDR[13:8].
- 2 VRSETUP: as 1, with last byte 0x00|ADDR[13:8].
- 3 VWDATA: P0:DATA[7:0].
- 4 VRDATA: P0 read.
- 5 STATRD: P1:{4'b0,ADDR[3:0]}, P1:0x8F, P1 read, P1:0x00, P1:0x8F.
- 6 PALWR: P1:{4'b0,ADDR[3:0]}, P1:0x90, P2:DATA[7:0], P2:DATA[15:8].
- 7: no bus cycle; o_ERR one-clock pulse on the clock after acceptance; return to IDLE.
REQ-013 SHALL run every port cycle through SETUP(1 enabled clk) -> STROBE(STROBE_LEN enabled clks) -> HOLD(1) -> GAP(GAP_LEN; skipped if 0), then the next step or IDLE.
REQ-014 SHALL drive o_MODE and o_CD_OUT from SETUP through HOLD; o_CD_OE high in SETUP..HOLD of write cycles only.
REQ-015 SHALL assert o_CSW_n (writes) or o_CSR_n (reads) low only during STROBE; never both low.
REQ-016 SHALL sample i_CD_IN on the last enabled clock of STROBE of a read cycle, and present it on o_RD_DATA with o_RD_VALID high for exactly one clock on the clock after HOLD completes; o_RD_DATA SHALL hold its value until the next read.
REQ-017 SHALL hold all state when i_CEN is low; handshake and acceptance are independent of i_CEN.
REQ-018 SHALL set o_BUSY high from the clock after acceptance until return to IDLE.
REQ-019 SHALL use a 3-bit step counter and a 4-bit phase counter; both SHALL saturate, not wrap, at the final step and phase.
REQ-020 SHALL not accept a new request in the clock it returns to IDLE; acceptance becomes possible one clock later.

Reset
REQ-021 SHALL, while i_RST is high on any edge, enter IDLE and set o_CSW_n=1, o_CSR_n=1, o_CD_OE=0, o_MODE=0, o_CD_OUT=0, o_RD_DATA=0, o_RD_VALID=0, o_BUSY=0, o_ERR=0, and hold o_REQ_READY low.
REQ-022 SHALL abort any sequence on reset mid-operation, including mid-STROBE, with no o_RD_VALID pulse and no further strobe; the aborted request is dropped.

Verification
REQ-023 SHALL pass: REGWR ADDR=7, DATA=0xF4, i_CEN=1 -> P1 writes 0xF4 then 0x87, each CSW_n low 4 clks, 2-clk gap, ready after 16+1 clks.
REQ-024 SHALL pass: VWSETUP ADDR=0x1ABCD -> P1 bytes 0x06, 0x8E, 0xCD, 0x6B.
REQ-025 SHALL pass: STATRD ADDR=2 with i_CD_IN=0x9F during the read -> five cycles, o_RD_DATA=0x9F with one-clock o_RD_VALID, then 0x00, 0x8F written.
REQ-026 SHALL pass: PALWR ADDR=5, DATA=0x0723 with i_CEN high every 3rd clk -> P1 0x05, 0x90, P2 0x23, 0x07; every phase stretched 3x.
REQ-027 SHALL pass: i_RST asserted during STROBE of VRDATA -> o_CSR_n=1 next clk, no o_RD_VALID, o_REQ_READY high one clk after i_RST falls.
REQ-028 SHALL pass: CMD=7 -> o_ERR single pulse, no strobe, ready restored.
